bd_tag_merge_n: RTL and testbench

- N-input generalisation of the BD tag/word merger.
- Merges NIN valid/ack data channels into one BD-bound channel and appends a per-input leaf code to each word: out_d = {payload, code}.
- Round-robin arbitration with a configurable burst hold; the output is registered.
- Sits between tag/count sources (router, accumulator, PC traffic) and the BD serializer.

---
 rtl/bd_tag_merge_n.sv | 124 ++++++++++++
 tb/tb_bd_tag_merge_n.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bd_tag_merge_n.sv
// N-input BD tag/word merger: round-robin with burst hold, registered {payload, code} output.
// Define BD_TAG_MERGE_STATS_EN to add saturating per-input transfer counters on stat_cnt.
module bd_tag_merge_n #(
  parameter int unsigned NIN = 4,
  parameter int unsigned NDATA = 24,
  parameter int unsigned NCODE = 6,
  // Input 0 occupies the least significant slice, so it is written last.
  parameter logic [NIN*NCODE-1:0] CODES = {6'd13, 6'd12, 6'd31, 6'd30},
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NIN-1:0]         in_v,
  input  logic [NIN*NDATA-1:0]   in_d,
  output logic [NIN-1:0]         in_a,
  output logic                   out_v,
  output logic [NDATA+NCODE-1:0] out_d,
  input  logic                   out_a
`ifdef BD_TAG_MERGE_STATS_EN
  ,
  output logic [NIN*16-1:0]      stat_cnt
`endif
);

  localparam int unsigned IW = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BurstMax = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LastRst = IW'(NIN - 1);

  logic                   out_v_q;
  logic [NDATA+NCODE-1:0] out_d_q;
  logic [IW-1:0]          last_q;
  logic [BW-1:0]          burst_q;
  logic                   hold_ok_q;

  logic                   load_en;
  logic                   gnt_any;
  logic [IW-1:0]          gnt_idx;
  logic [NIN-1:0]         gnt_oh;
  logic [NDATA-1:0]       sel_d;
  logic [NCODE-1:0]       sel_code;

  assign load_en = !out_v_q || out_a;
  assign out_v   = out_v_q;
  assign out_d   = out_d_q;

  // After reset last_q holds only its reset value, so it may not claim a hold until it has
  // actually transferred.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (hold_ok_q && in_v[last_q] && (burst_q < BurstMax)) begin
      gnt_any = 1'b1;
      gnt_idx = last_q;
    end else begin
      for (int unsigned k = 1; k <= NIN; k++) begin
        idx = (32'(last_q) + k) % NIN;
        if (!gnt_any && in_v[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt_oh   = '0;
    sel_d    = '0;
    sel_code = '0;
    for (int unsigned i = 0; i < NIN; i++) begin
      if (gnt_any && (gnt_idx == IW'(i))) begin
        gnt_oh[i] = 1'b1;
        sel_d     = in_d[i*NDATA +: NDATA];
        sel_code  = CODES[i*NCODE +: NCODE];
      end
    end
  end

  assign in_a = (load_en && !reset) ? gnt_oh : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v_q   <= 1'b0;
      out_d_q   <= '0;
      last_q    <= LastRst;
      burst_q   <= '0;
      hold_ok_q <= 1'b0;
    end else if (load_en) begin
      out_v_q <= gnt_any;
      if (gnt_any) begin
        out_d_q   <= {sel_d, sel_code};
        hold_ok_q <= 1'b1;
        if (gnt_idx == last_q) begin
          if (burst_q != BurstMax) burst_q <= burst_q + 1'b1;
        end else begin
          last_q  <= gnt_idx;
          burst_q <= '0;
        end
      end
    end
  end

`ifdef BD_TAG_MERGE_STATS_EN
  logic [15:0] cnt_q [NIN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NIN; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NIN; i++) begin
        if (in_a[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int unsigned i = 0; i < NIN; i++) stat_cnt[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_bd_tag_merge_n.sv
// Scoreboard bench for bd_tag_merge_n: MAX_BURST=4 instance plus a MAX_BURST=1 instance.
module tb_bd_tag_merge_n;

  logic        clk;
  logic        reset;
  logic [3:0]  in_v, in_v1;
  logic [95:0] in_d;
  logic [3:0]  in_a, in_a1;
  logic        out_v, out_v1;
  logic [29:0] out_d, out_d1;
  logic        out_a, out_a1;
`ifdef BD_TAG_MERGE_STATS_EN
  logic [63:0] stat_cnt, stat_cnt1;
`endif

  int total = 0;
  int bad = 0;
  logic [29:0] sb0[$];
  logic [29:0] sb1[$];

  logic [23:0] pay[4] = '{24'hABCDEF, 24'h123456, 24'h5A5A5A, 24'hC0FFEE};
  logic [5:0]  cd[4]  = '{6'd30, 6'd31, 6'd12, 6'd13};

  bd_tag_merge_n #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .in_v(in_v), .in_d(in_d), .in_a(in_a),
    .out_v(out_v), .out_d(out_d), .out_a(out_a)
`ifdef BD_TAG_MERGE_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  bd_tag_merge_n #(.MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset), .in_v(in_v1), .in_d(in_d), .in_a(in_a1),
    .out_v(out_v1), .out_d(out_d1), .out_a(out_a1)
`ifdef BD_TAG_MERGE_STATS_EN
    , .stat_cnt(stat_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] w(int i);
    return {pay[i], cd[i]};
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_v && out_a) begin
      if (sb0.size() == 0) begin
        total++; bad++;
        $display("FAIL sb0_extra got=%0h exp=none", out_d);
      end else begin
        chk("sb0_word", {34'd0, out_d}, {34'd0, sb0.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_v1 && out_a1) begin
      if (sb1.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1_extra got=%0h exp=none", out_d1);
      end else begin
        chk("sb1_word", {34'd0, out_d1}, {34'd0, sb1.pop_front()});
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_v = '0; in_v1 = '0; out_a = 1'b1; out_a1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 20 && (sb0.size() != 0 || sb1.size() != 0); i++) @(negedge clk);
    chk(name, sb0.size() + sb1.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_v = '0; in_v1 = '0; out_a = 1'b1; out_a1 = 1'b1;
    in_d = {pay[3], pay[2], pay[1], pay[0]};
    #3 in_v = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_v", out_v, 0);
    chk("rst_out_d", out_d, 0);
    chk("rst_in_a", in_a, 0);
    in_v = '0;
    reset = 1'b0;

    // Single source, sustained one word per cycle.
    repeat (4) sb0.push_back(w(0));
    in_v = 4'b0001;
    repeat (4) begin
      tick();
      chk("single_out_v", out_v, 1);
    end
    in_v = '0;
    drain("single_drain");

    // All inputs valid: bursts of 4 on dut, pure round-robin on dut1.
    do_reset();
    for (int g = 0; g < 18; g++) sb0.push_back(w((g / 4) % 4));
    for (int g = 0; g < 10; g++) sb1.push_back(w(g % 4));
    in_v = 4'hF; in_v1 = 4'hF;
    for (int k = 0; k < 18; k++) begin
      if (k == 10) in_v1 = '0;
      tick();
    end
    in_v = '0;
    drain("rr_drain");

    // Backpressure freezes the output and blocks every input.
    do_reset();
    sb0.push_back(w(0)); sb0.push_back(w(0));
    in_v = 4'hF;
    tick();
    out_a = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_a", in_a, 0);
      chk("bp_out_d", out_d, w(0));
      chk("bp_out_v", out_v, 1);
      tick();
    end
    out_a = 1'b1;
    @(negedge clk);
    chk("bp_release_in_a", in_a, 4'b0001);
    tick();
    in_v = '0;
    drain("bp_drain");

    // Burst break: held input drops, next grant restarts the burst count.
    do_reset();
    sb0.push_back(w(1)); sb0.push_back(w(1));
    repeat (4) sb0.push_back(w(3));
    sb0.push_back(w(1));
    in_v = 4'b0010;
    tick(); tick();
    in_v = 4'b1000;
    @(negedge clk);
    chk("brk_in_a", in_a, 4'b1000);
    tick();
    in_v = 4'b1010;
    tick(); tick(); tick();
    @(negedge clk);
    chk("brk_rotate_in_a", in_a, 4'b0010);
    tick();
    in_v = '0;
    drain("brk_drain");

    // Asynchronous reset while holding a word.
    do_reset();
    in_v = 4'b0001;
    tick();
    out_a = 1'b0; in_v = '0;
    #2;
    chk("async_pre_out_v", out_v, 1);
    reset = 1'b1;
    #1;
    chk("async_out_v", out_v, 0);
    chk("async_in_a", in_a, 0);
    tick();
    reset = 1'b0; in_v = 4'hF; out_a = 1'b1;
    sb0.push_back(w(0));
    @(negedge clk);
    chk("async_first_grant", in_a, 4'b0001);
    tick();
    in_v = '0;
    drain("async_drain");

`ifdef BD_TAG_MERGE_STATS_EN
    do_reset();
    repeat (3) sb0.push_back(w(0));
    repeat (5) sb0.push_back(w(1));
    repeat (70000) sb0.push_back(w(2));
    in_v = 4'b0001;
    repeat (3) tick();
    in_v = 4'b0010;
    repeat (5) tick();
    in_v = 4'b0100;
    repeat (70000) tick();
    in_v = '0;
    drain("stats_drain");
    @(negedge clk);
    chk("stat0", stat_cnt[15:0], 16'd3);
    chk("stat1", stat_cnt[31:16], 16'd5);
    chk("stat2", stat_cnt[47:32], 16'hFFFF);
    chk("stat3", stat_cnt[63:48], 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
